inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Responder side of the PC unit's address handshake.
- Accepts instruction addresses (valid/ready), issues one word read at a time to the instruction-memory bus (req/gnt, then rvalid), and buffers returned {addr, inst} pairs in a small FIFO toward decode.
- A jump flush discards buffered and in-flight fetches.

Parameters:
- FIFO_DEPTH, 4, response FIFO entries; power of two, >= 2.
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- valid_i  input  1  PC unit presents a fetch address
- instAddr_i  input  ADDR_W  fetch address
- ready_o  output  1  fetch unit accepts address this cycle
- flush_i  input  1  jump taken; discard all older fetches
- memReq_o  output  1  memory read request
- memAddr_o  output  ADDR_W  memory read address
- memGnt_i  input  1  memory accepted request
- memRvalid_i  input  1  read data valid
- memRdata_i  input  DATA_W  read data
- instValid_o  output  1  FIFO head valid toward decode
- inst_o  output  DATA_W  FIFO head instruction
- instAddr_o  output  ADDR_W  FIFO head address
- instReady_i  input  1  decode consumes head

Behaviour:
- Reset values: ready_o 0; memReq_o 0; memAddr_o 0; instValid_o 0; inst_o 0; instAddr_o 0; FIFO empty; state IDLE.
- Address handshake:
  - ready_o = (state==IDLE) & ~fifoFull & ~flush_i, combinational from registered state/count.
  - Accept when valid_i & ready_o; instAddr_i is captured into memAddr_o.
- States (one outstanding read maximum):
  - IDLE: on accept -> REQ.
  - REQ: memReq_o=1, memAddr_o stable. On memGnt_i -> WAIT. If flush_i: the request is not withdrawn; on grant -> DROP, otherwise stay in REQ marked "drop-pending" and go to DROP at grant.
  - WAIT: on memRvalid_i, push {memAddr_o, memRdata_i} -> IDLE. If flush_i without rvalid -> DROP. If flush_i with rvalid in the same cycle, data is discarded -> IDLE.
  - DROP: on memRvalid_i, discard -> IDLE. flush_i has no further effect.
- Latency: accept at edge N; memReq_o high from N+1. Grant at N+1 with rvalid at N+2 gives instValid_o high at N+3. Minimum address-to-address period is 3 cycles.
- FIFO behaviour:
  - instValid_o = ~empty; head fields are registered FIFO outputs.
  - Pop on instValid_o & instReady_i. Push and pop may occur in the same cycle.
  - A full FIFO blocks new accepts only. An in-flight response is always guaranteed a slot, because accept requires ~fifoFull and pops only free entries.
- Flush: clears the FIFO at the same edge, with priority over push and pop. instValid_o is 0 the cycle after flush_i. ready_o is 0 during the flush cycle itself.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Asynchronous reset mid-transaction returns to IDLE immediately. The memory side is reset by the same reset_n.

Optional Feature:
- IFU_MISALIGN_CHK_EN defined:
  - An accepted address with instAddr_i[1:0]!=0 is not sent to memory.
  - Next cycle, a FIFO entry {instAddr_i, 32'h00000013 (NOP)} is pushed directly.
  - Adds output instErr_o (1 bit), valid with the head and set for such entries.
- Not defined: low address bits are passed to memAddr_o unchanged, and the instErr_o port does not exist.

Decomposition:
- Package ifu_pkg: state encoding (IDLE, REQ, WAIT, DROP), NOP_INST constant, default widths.
- One sub-module, ifu_resp_fifo: synchronous FIFO with flush, count, full/empty.

Test Plan:
1. Reset, then valid_i=1 with instAddr_i=0x0; memory grants the same cycle and returns 0x00500093 one cycle later -> instValid_o=1 at cycle 3 with instAddr_o=0x0, inst_o=0x00500093.
2. Hold instReady_i=0 while fetching 0x0, 0x4, 0x8, 0xC -> after 4 pushes ready_o=0 with no memReq_o. Raise instReady_i for one cycle -> next accept at 0x10.
3. flush_i in WAIT, rvalid two cycles later -> that data is never visible, FIFO is empty, and the next address 0x100 is fetched and delivered alone.
4. flush_i in REQ with memGnt_i delayed 3 cycles -> memReq_o stays high until grant, the response is dropped, state returns to IDLE.
5. flush_i and memRvalid_i in the same cycle with 2 entries buffered -> FIFO is empty the next cycle and the response is discarded.
6. With IFU_MISALIGN_CHK_EN, address 0x6 -> no memReq_o; entry {0x6, 0x00000013} with instErr_o=1 appears.

Source files
------------

// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit:
//   - ifu_state_e : fetch FSM states (IDLE, REQ, WAIT, DROP)
//   - NOP_INST    : instruction substituted for misaligned fetches
//   - default parameter values for depth and widths
// Optional feature macro used by the fetch unit: IFU_MISALIGN_CHK_EN.
// ----------------------------------------------------------------------------
package ifu_pkg;

  localparam int IFU_FIFO_DEPTH_DEF = 4;
  localparam int IFU_ADDR_W_DEF     = 32;
  localparam int IFU_DATA_W_DEF     = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // ready for a new address
    S_REQ  = 2'd1,  // request on the bus, waiting for grant
    S_WAIT = 2'd2,  // granted, waiting for read data
    S_DROP = 2'd3   // granted, read data will be discarded
  } ifu_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// inst_fetch_unit_if
// Bundles the three handshakes of the fetch unit:
//   PC side     : valid_i, instAddr_i, ready_o, flush_i
//   memory side : memReq_o, memAddr_o, memGnt_i, memRvalid_i, memRdata_i
//   decode side : instValid_o, inst_o, instAddr_o, instReady_i
//                 (+ instErr_o when IFU_MISALIGN_CHK_EN is defined)
// Signal suffixes are from the fetch unit's point of view.
// Modports: slave  = the fetch unit itself
//           master = the surrounding environment (PC unit, memory, decode)
// ----------------------------------------------------------------------------
interface inst_fetch_unit_if
  import ifu_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W_DEF,
  parameter int DATA_W = IFU_DATA_W_DEF
);

  logic              valid_i;
  logic [ADDR_W-1:0] instAddr_i;
  logic              ready_o;
  logic              flush_i;

  logic              memReq_o;
  logic [ADDR_W-1:0] memAddr_o;
  logic              memGnt_i;
  logic              memRvalid_i;
  logic [DATA_W-1:0] memRdata_i;

  logic              instValid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] instAddr_o;
  logic              instReady_i;
`ifdef IFU_MISALIGN_CHK_EN
  logic              instErr_o;
`endif

  modport slave (
    input  valid_i, instAddr_i, flush_i,
    input  memGnt_i, memRvalid_i, memRdata_i,
    input  instReady_i,
    output ready_o, memReq_o, memAddr_o,
    output instValid_o, inst_o, instAddr_o
`ifdef IFU_MISALIGN_CHK_EN
    , instErr_o
`endif
  );

  modport master (
    output valid_i, instAddr_i, flush_i,
    output memGnt_i, memRvalid_i, memRdata_i,
    output instReady_i,
    input  ready_o, memReq_o, memAddr_o,
    input  instValid_o, inst_o, instAddr_o
`ifdef IFU_MISALIGN_CHK_EN
    , instErr_o
`endif
  );

endinterface

// File: rtl/ifu_resp_fifo.sv
// ----------------------------------------------------------------------------
// ifu_resp_fifo
// Synchronous FIFO holding fetched {addr, inst} entries toward decode.
// The head entry is kept in a dedicated register so the outputs are
// registered and read zero out of reset.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   flush_i        empties the FIFO; wins over push and pop
//   push_i/data_i  write an entry (ignored when full)
//   pop_i          remove the head entry (ignored when empty)
//   data_o         head entry
//   full_o/empty_o occupancy flags
// ----------------------------------------------------------------------------
module ifu_resp_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(rd_en);
  assign count_nxt  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

  // NOTE: storage has no reset; only pointers/count define validity, and
  // leaving the array unreset lets it map onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (wr_en && !flush_i) mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_o   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      // Refresh the head register with whatever will sit at the read
      // pointer after this edge; the slot being written this cycle is
      // not in the array yet, so take it straight from data_i.
      if (count_nxt != '0)
        data_o <= (wr_en && (rd_ptr_nxt == wr_ptr_q)) ? data_i : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// ----------------------------------------------------------------------------
// inst_fetch_unit
// Takes fetch addresses from the PC unit, performs one instruction-memory
// read at a time (req/gnt, then rvalid) and queues {addr, inst} pairs for
// decode. A flush (taken jump) empties the queue and discards any read
// still in flight; a request already on the bus is never withdrawn.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      inst_fetch_unit_if.slave (PC, memory and decode handshakes)
// Optional feature: define IFU_MISALIGN_CHK_EN to turn misaligned addresses
// into a NOP entry flagged on instErr_o instead of a memory read.
// ----------------------------------------------------------------------------
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int FIFO_DEPTH = IFU_FIFO_DEPTH_DEF,
  parameter int ADDR_W     = IFU_ADDR_W_DEF,
  parameter int DATA_W     = IFU_DATA_W_DEF
) (
  input logic             clk,
  input logic             reset_n,
  inst_fetch_unit_if.slave bus
);

`ifdef IFU_MISALIGN_CHK_EN
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
`else
  localparam int ENTRY_W = ADDR_W + DATA_W;
`endif

  ifu_state_e        state_q;
  logic              drop_pend_q;   // flush seen while still waiting for grant
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic               fifo_full, fifo_empty;
  logic               fifo_push, fifo_pop;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               accept, resp_push, send_to_mem;

`ifdef IFU_MISALIGN_CHK_EN
  logic mis_pend_q;   // misaligned address accepted; NOP entry pushed next edge

  assign send_to_mem = (bus.instAddr_i[1:0] == 2'b00);
  // reset_n gating keeps ready_o low while the unit is held in reset.
  assign bus.ready_o = reset_n & (state_q == S_IDLE) & ~fifo_full &
                       ~bus.flush_i & ~mis_pend_q;
`else
  assign send_to_mem = 1'b1;
  assign bus.ready_o = reset_n & (state_q == S_IDLE) & ~fifo_full & ~bus.flush_i;
`endif

  assign accept = bus.valid_i & bus.ready_o;

  // NOTE: every register below is assigned with <= so all state updates
  // observe pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      drop_pend_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
`ifdef IFU_MISALIGN_CHK_EN
      mis_pend_q  <= 1'b0;
`endif
    end else begin
`ifdef IFU_MISALIGN_CHK_EN
      mis_pend_q <= accept & ~send_to_mem;
`endif
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mem_addr_q <= bus.instAddr_i;
            if (send_to_mem) begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              drop_pend_q <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (bus.memGnt_i) begin
            mem_req_q   <= 1'b0;
            drop_pend_q <= 1'b0;
            state_q     <= (drop_pend_q | bus.flush_i) ? S_DROP : S_WAIT;
          end else if (bus.flush_i) begin
            drop_pend_q <= 1'b1;
          end
        end
        S_WAIT: begin
          // A flush coinciding with rvalid is covered by the FIFO flush.
          if (bus.memRvalid_i)   state_q <= S_IDLE;
          else if (bus.flush_i)  state_q <= S_DROP;
        end
        S_DROP: begin
          if (bus.memRvalid_i) state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.memReq_o  = mem_req_q;
  assign bus.memAddr_o = mem_addr_q;

  assign resp_push = (state_q == S_WAIT) & bus.memRvalid_i;
  assign fifo_pop  = ~fifo_empty & bus.instReady_i;

`ifdef IFU_MISALIGN_CHK_EN
  assign fifo_push = resp_push | mis_pend_q;
  assign fifo_din  = mis_pend_q ? {1'b1, mem_addr_q, DATA_W'(NOP_INST)}
                                : {1'b0, mem_addr_q, bus.memRdata_i};
  assign {bus.instErr_o, bus.instAddr_o, bus.inst_o} = fifo_dout;
`else
  assign fifo_push = resp_push;
  assign fifo_din  = {mem_addr_q, bus.memRdata_i};
  assign {bus.instAddr_o, bus.inst_o} = fifo_dout;
`endif

  assign bus.instValid_o = ~fifo_empty;

  ifu_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_resp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (bus.flush_i),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
